regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_REQ producers (ALU, multiplier/divider, load unit) using round-robin arbitration with a valid/ready handshake.
- One grant per cycle; the winning write is registered and presented to the register file one cycle later.
- Writes to x0 are absorbed without using the port.
- Sits between execute/memory writeback sources and the word-wide register storage.

---
 rtl/regfile_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single register-file write port between NUM_REQ writeback
// producers (0 = ALU, 1 = mul/div, 2 = load unit) with round-robin priority.
// At most one write is granted per cycle. The granted write is registered and
// presented to the register file one cycle later. Writes to x0 are accepted
// immediately and discarded, so they never use the port.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   port_enable  register-file port available this cycle (0 = accept nothing)
//   flush        kill the write being loaded into the output register
//   req_valid    per-requester write request
//   req_addr     packed destination indexes, requester i at [i*RAW +: RAW]
//   req_data     packed write data, requester i at [i*WS +: WS]
//   req_ready    combinational accept per requester
//   wr_en        registered write strobe
//   wr_addr      registered write index
//   wr_data      registered write data
//   last_grant   index of the most recent real grant (debug / perf counters)
//
// Handshake: a transfer on requester i happens in any cycle where
// req_valid[i] & req_ready[i] is 1 at the rising edge. req_ready is built only
// from req_valid, req_addr, port_enable, last_grant and reset, never from
// req_data, so a producer may compute its data from req_ready without forming
// a loop. Producers hold valid/addr/data stable until accepted.
//
// NUM_REQ must be at least 2 so that last_grant has a nonzero width.

module regfile_write_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int WORD_SIZE      = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              port_enable,
   input  logic                              flush,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*WORD_SIZE-1:0]      req_data,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic                              wr_en,
   output logic [REG_ADDR_WIDTH-1:0]         wr_addr,
   output logic [WORD_SIZE-1:0]              wr_data,
   output logic [$clog2(NUM_REQ)-1:0]        last_grant
);

   localparam int LG_W = $clog2(NUM_REQ);

   logic                      wr_en_q,      wr_en_d;
   logic [REG_ADDR_WIDTH-1:0] wr_addr_q,    wr_addr_d;
   logic [WORD_SIZE-1:0]      wr_data_q,    wr_data_d;
   logic [LG_W-1:0]           last_grant_q, last_grant_d;

   logic [NUM_REQ-1:0]        real_req;
   logic [NUM_REQ-1:0]        null_req;
   logic                      accept_ok;
   logic                      grant_found;
   logic [LG_W-1:0]           grant_idx;
   logic [REG_ADDR_WIDTH-1:0] grant_addr;
   logic [WORD_SIZE-1:0]      grant_data;

   // A request pending while reset is high must not be accepted, so reset
   // blocks acceptance the same way a busy port does.
   assign accept_ok = port_enable & ~reset;

   always_comb begin
      real_req = '0;
      null_req = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i]) begin
            if (req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0) begin
               null_req[i] = 1'b1;
            end else begin
               real_req[i] = 1'b1;
            end
         end
      end
   end

   // Round-robin search starting one past the last winner. The modulo keeps
   // the scan correct for any NUM_REQ, including non powers of two.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && real_req[i] &&
                (i == ((int'(last_grant_q) + k) % NUM_REQ))) begin
               grant_found = 1'b1;
               grant_idx   = LG_W'(i);
            end
         end
      end
      if (!accept_ok) begin
         grant_found = 1'b0;
      end
   end

   always_comb begin
      req_ready  = '0;
      grant_addr = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept_ok && null_req[i]) begin
            req_ready[i] = 1'b1;
         end
         if (grant_found && (grant_idx == LG_W'(i))) begin
            req_ready[i] = 1'b1;
            grant_addr   = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            grant_data   = req_data[i*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

   // A flushed grant is still consumed and still advances the rotation; only
   // the strobe is suppressed. Address/data keep the last real write.
   always_comb begin
      wr_en_d      = grant_found & ~flush;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      last_grant_d = last_grant_q;
      if (wr_en_d) begin
         wr_addr_d = grant_addr;
         wr_data_d = grant_data;
      end
      if (grant_found) begin
         last_grant_d = grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         last_grant_q <= LG_W'(NUM_REQ - 1);
      end else begin
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a table of per-cycle vectors with
// hand-computed results, followed by hand-written reset/flush sequences.

module tb_regfile_write_arbiter;

   localparam int NR = 3;
   localparam int WS = 32;
   localparam int AW = 5;

   logic             clk;
   logic             reset;
   logic             port_enable;
   logic             flush;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*WS-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WS-1:0]    wr_data;
   logic [1:0]       last_grant;

   int checks = 0;
   int errors = 0;

   logic [AW+WS-1:0] exp_q[$];

   regfile_write_arbiter #(
      .NUM_REQ(NR), .WORD_SIZE(WS), .REG_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset(reset), .port_enable(port_enable), .flush(flush),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .last_grant(last_grant)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  valid;
      logic [4:0]  a0, a1, a2;
      logic [31:0] d0, d1, d2;
      logic        pe;
      logic        fl;
      logic [2:0]  exp_ready;
      logic        exp_wr_en;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      logic [1:0]  exp_lg;
      logic        chk_hold;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic pe, input logic fl);
      req_valid   = v;
      req_addr    = {a2, a1, a0};
      req_data    = {d2, d1, d0};
      port_enable = pe;
      flush       = fl;
   endtask

   task automatic drive_idle();
      drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
   endtask

   // Registered outputs after an edge; writes are matched against the
   // scoreboard queue in order.
   task automatic check_out(input string name, input logic exp_en, input logic [1:0] exp_lg);
      logic [AW+WS-1:0] e;
      check({name, ".wr_en"}, 64'(wr_en), 64'(exp_en));
      check({name, ".last_grant"}, 64'(last_grant), 64'(exp_lg));
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check({name, ".unexpected_write"}, 64'({wr_addr, wr_data}), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check({name, ".wr_addr_data"}, 64'({wr_addr, wr_data}), 64'(e));
         end
      end
   endtask

   function automatic vec_t mk(input string name, input logic [2:0] valid,
                               input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                               input logic pe, input logic fl, input logic [2:0] er,
                               input logic ee, input logic [4:0] ea, input logic [31:0] ed,
                               input logic [1:0] elg, input logic hold);
      vec_t v;
      v.name = name; v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
      v.d0 = d0; v.d1 = d1; v.d2 = d2; v.pe = pe; v.fl = fl;
      v.exp_ready = er; v.exp_wr_en = ee; v.exp_addr = ea; v.exp_data = ed;
      v.exp_lg = elg; v.chk_hold = hold;
      return v;
   endfunction

   initial begin
      logic [31:0] da, db, dc;
      da = 32'h1111_1111; db = 32'h2222_2222; dc = 32'h3333_3333;

      // Per-cycle vectors; state carries from one row to the next.
      vecs.push_back(mk("single_req0", 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 0, 0, 1, 0,
                        3'b001, 1, 5'd5, 32'hDEADBEEF, 2'd0, 0));
      vecs.push_back(mk("x0_filter", 3'b110, 5'd0, 5'd0, 5'd7, 0, 32'h55, 32'h77, 1, 0,
                        3'b110, 1, 5'd7, 32'h77, 2'd2, 0));
      vecs.push_back(mk("rr0", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 1, 0, 3'b001, 1, 5'd1, da, 2'd0, 0));
      vecs.push_back(mk("rr1", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 1, 0, 3'b010, 1, 5'd2, db, 2'd1, 0));
      vecs.push_back(mk("rr2", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 1, 0, 3'b100, 1, 5'd3, dc, 2'd2, 0));
      vecs.push_back(mk("rr3", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 1, 0, 3'b001, 1, 5'd1, da, 2'd0, 0));
      vecs.push_back(mk("rr4", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 1, 0, 3'b010, 1, 5'd2, db, 2'd1, 0));
      vecs.push_back(mk("rr5", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 1, 0, 3'b100, 1, 5'd3, dc, 2'd2, 0));
      vecs.push_back(mk("pe_off0", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 0, 0, 3'b000, 0, 5'd3, dc, 2'd2, 1));
      vecs.push_back(mk("pe_off1", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 0, 0, 3'b000, 0, 5'd3, dc, 2'd2, 1));
      vecs.push_back(mk("pe_off2", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 0, 0, 3'b000, 0, 5'd3, dc, 2'd2, 1));
      vecs.push_back(mk("pe_on", 3'b111, 5'd1, 5'd2, 5'd3, da, db, dc, 1, 0, 3'b001, 1, 5'd1, da, 2'd0, 0));
      vecs.push_back(mk("flush_grant", 3'b100, 5'd0, 5'd0, 5'd9, 0, 0, 32'h99, 1, 1,
                        3'b100, 0, 5'd0, 0, 2'd2, 0));
      vecs.push_back(mk("null_only", 3'b010, 5'd0, 5'd0, 5'd0, 0, 32'hAB, 0, 1, 0,
                        3'b010, 0, 5'd0, 0, 2'd2, 0));
      vecs.push_back(mk("null_pe_off", 3'b001, 5'd0, 5'd0, 5'd0, 32'hCD, 0, 0, 0, 0,
                        3'b000, 0, 5'd0, 0, 2'd2, 0));
      vecs.push_back(mk("idle", 3'b000, 5'd4, 5'd4, 5'd4, 0, 0, 0, 1, 0,
                        3'b000, 0, 5'd0, 0, 2'd2, 0));

      // reset
      reset = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset.wr_en", 64'(wr_en), 64'd0);
      check("reset.wr_addr", 64'(wr_addr), 64'd0);
      check("reset.wr_data", 64'(wr_data), 64'd0);
      check("reset.last_grant", 64'(last_grant), 64'd2);

      // table vectors
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2,
               vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].pe, vecs[i].fl);
         #3;
         check({vecs[i].name, ".req_ready"}, 64'(req_ready), 64'(vecs[i].exp_ready));
         if (vecs[i].exp_wr_en) exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_data});
         @(posedge clk);
         #1;
         check_out(vecs[i].name, vecs[i].exp_wr_en, vecs[i].exp_lg);
         if (vecs[i].chk_hold) begin
            check({vecs[i].name, ".hold_addr"}, 64'(wr_addr), 64'(vecs[i].exp_addr));
            check({vecs[i].name, ".hold_data"}, 64'(wr_data), 64'(vecs[i].exp_data));
         end
      end

      // A write already on the outputs completes even when flush arrives.
      drive(3'b001, 5'd4, 5'd0, 5'd0, 32'h44, 0, 0, 1'b1, 1'b0);
      #3;
      check("pre_flush.req_ready", 64'(req_ready), 64'b001);
      exp_q.push_back({5'd4, 32'h44});
      @(posedge clk);
      #1;
      drive(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b1, 1'b1);
      check_out("pre_flush", 1'b1, 2'd0);
      @(posedge clk);
      #1;
      check_out("post_flush", 1'b0, 2'd0);

      // Reset mid-operation: req1 would win, but reset drops it.
      drive(3'b010, 5'd0, 5'd6, 5'd0, 0, 32'h66, 0, 1'b1, 1'b0);
      reset = 1'b1;
      #3;
      check("mid_reset.req_ready", 64'(req_ready), 64'b000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_out("mid_reset", 1'b0, 2'd2);
      check("mid_reset.wr_addr", 64'(wr_addr), 64'd0);
      drive(3'b011, 5'd8, 5'd6, 5'd0, 32'h88, 32'h66, 0, 1'b1, 1'b0);
      #3;
      check("after_reset.req_ready", 64'(req_ready), 64'b001);
      exp_q.push_back({5'd8, 32'h88});
      @(posedge clk);
      #1;
      drive_idle();
      check_out("after_reset", 1'b1, 2'd0);

      // final report
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
